// File: rtl/alu_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB first.
// Results, busy, done and div_by_zero are registered; a zero divisor skips the iteration.
module alu_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] first,
    input  logic [WIDTH-1:0] second,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned RW = WIDTH + 1;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] quo_q;
    logic [RW-1:0]    rem_q;
    logic [CW-1:0]    cnt_q;

    logic [RW-1:0]    shifted;
    logic [RW-1:0]    trial;
    logic             ge;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a zero divisor goes straight to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (second == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One restoring step: the extra remainder bit keeps compare/subtract overflow-free
    always_comb begin
        shifted = (rem_q << 1) | RW'(dividend_q[WIDTH-1]);
        ge      = (shifted >= {1'b0, divisor_q});
        trial   = shifted - {1'b0, divisor_q};
    end

    // Datapath and registered outputs; results only change on the DONE cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dividend_q  <= '0;
            divisor_q   <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dividend_q  <= first;
                        divisor_q   <= second;
                        quo_q       <= '0;
                        rem_q       <= '0;
                        cnt_q       <= '0;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                    end
                end
                CALC: begin
                    rem_q      <= ge ? trial : shifted;
                    dividend_q <= dividend_q << 1;
                    quo_q      <= (quo_q << 1) | WIDTH'(ge);
                    cnt_q      <= cnt_q + CW'(1);
                end
                DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (divisor_q == '0) begin
                        quotient    <= '1;
                        remainder   <= dividend_q;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient  <= quo_q;
                        remainder <= rem_q[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_divider.sv
// Directed self-checking bench for alu_divider (WIDTH=8) with immediate assertions.
module tb_alu_divider;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [WIDTH-1:0] first;
    logic [WIDTH-1:0] second;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    int checks = 0;
    int errors = 0;

    alu_divider #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .first      (first),
        .second     (second),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start, scramble operands after acceptance, wait (bounded) for done
    task automatic do_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output int lat);
        first  = a;
        second = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        first  = ~a;
        second = ~b;
        lat    = 0;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int pulses;
        logic [WIDTH-1:0] cap_q;
        logic [WIDTH-1:0] cap_r;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;

        reset_n = 1'b0;
        start   = 1'b0;
        first   = '0;
        second  = '0;
        repeat (3) tick();
        check("rst_quotient", 32'(quotient), 0);
        check("rst_remainder", 32'(remainder), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_dbz", 32'(div_by_zero), 0);
        reset_n = 1'b1;
        tick();
        check("post_rst_done", 32'(done), 0);

        // 128/1: done after the 9th edge following the start edge
        first = 8'd128; second = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin tick(); lat++; end
        check("lat_128_1", 32'(lat), 9);
        check("q_128_1", 32'(quotient), 128);
        check("r_128_1", 32'(remainder), 0);
        check("dbz_128_1", 32'(div_by_zero), 0);
        check("busy_at_done", 32'(busy), 0);
        tick();
        check("done_one_cycle", 32'(done), 0);

        do_div(8'd200, 8'd7, lat);
        check("q_200_7", 32'(quotient), 28);
        check("r_200_7", 32'(remainder), 4);
        do_div(8'd255, 8'd255, lat);
        check("q_255_255", 32'(quotient), 1);
        check("r_255_255", 32'(remainder), 0);
        do_div(8'd7, 8'd9, lat);
        check("q_7_9", 32'(quotient), 0);
        check("r_7_9", 32'(remainder), 7);

        // Divide by zero: short path, saturated quotient, dividend as remainder
        do_div(8'd5, 8'd0, lat);
        check("lat_div0", 32'(lat), 1);
        check("q_div0", 32'(quotient), 255);
        check("r_div0", 32'(remainder), 5);
        check("dbz_div0", 32'(div_by_zero), 1);
        check("busy_div0", 32'(busy), 0);
        tick();
        check("dbz_hold", 32'(div_by_zero), 1);

        // Next valid start clears div_by_zero; old results held during CALC
        first = 8'd100; second = 8'd10; start = 1'b1;
        tick();
        start = 1'b0;
        check("dbz_cleared", 32'(div_by_zero), 0);
        repeat (3) tick();
        check("q_hold_calc", 32'(quotient), 255);
        check("r_hold_calc", 32'(remainder), 5);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin tick(); lat++; end
        check("q_100_10", 32'(quotient), 10);
        tick();

        // Start during CALC is ignored; exactly one done
        first = 8'd200; second = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        first = 8'd64; second = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        cap_q = '0;
        cap_r = '0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin
                pulses++;
                cap_q = quotient;
                cap_r = remainder;
            end
            tick();
        end
        check("ignored_pulses", 32'(pulses), 1);
        check("ignored_q", 32'(cap_q), 28);
        check("ignored_r", 32'(cap_r), 4);

        // Reset in the middle of CALC
        first = 8'd200; second = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("busy_before_abort", 32'(busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_quotient", 32'(quotient), 0);
        check("abort_remainder", 32'(remainder), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_dbz", 32'(div_by_zero), 0);
        tick();
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        check("abort_no_done", 32'(pulses), 0);
        do_div(8'd100, 8'd10, lat);
        check("lat_after_abort", 32'(lat), 9);
        check("q_after_abort", 32'(quotient), 10);
        check("r_after_abort", 32'(remainder), 0);

        // Random sweep with periodic zero divisors
        for (int i = 0; i < 1000; i++) begin
            a = WIDTH'($urandom);
            b = (i % 10 == 0) ? '0 : WIDTH'($urandom);
            do_div(a, b, lat);
            if (b == '0) begin
                check("sweep_q_div0", 32'(quotient), 255);
                check("sweep_r_div0", 32'(remainder), 32'(a));
                check("sweep_dbz", 32'(div_by_zero), 1);
            end else begin
                check("sweep_q", 32'(quotient), 32'(a / b));
                check("sweep_r", 32'(remainder), 32'(a % b));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_divider.md
ALU_DIVIDER -- requirements
Module: alu_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, a request to begin a division; sampled on the rising edge of clk.
REQ-005 The block SHALL have port first, input, WIDTH, the unsigned dividend, sampled when start is accepted.
REQ-006 The block SHALL have port second, input, WIDTH, the unsigned divisor, sampled when start is accepted.
REQ-007 The block SHALL have port quotient, output, WIDTH, the registered unsigned quotient.
REQ-008 The block SHALL have port remainder, output, WIDTH, the registered unsigned remainder.
REQ-009 The block SHALL have port busy, output, 1, high while a division is in progress.
REQ-010 The block SHALL have port done, output, 1, a one-cycle pulse marking valid quotient and remainder.
REQ-011 The block SHALL have port div_by_zero, output, 1, high with done when the latched divisor was 0.

Function
REQ-012 The block SHALL implement a state machine with exactly three states: IDLE, CALC and DONE.
REQ-013 In IDLE with start=1, the block SHALL latch first and second, clear the partial remainder and set busy=1 on that edge.
REQ-014 If the latched divisor is nonzero, the block SHALL go from IDLE to CALC; if it is 0, the block SHALL go directly to DONE.
REQ-015 In CALC, the block SHALL perform one restoring-division step per cycle, MSB first: shift the partial remainder left by 1 and bring in the next dividend bit; if the result is >= divisor, subtract the divisor and set the quotient bit to 1, otherwise set it to 0.
REQ-016 The partial remainder SHALL be WIDTH+1 bits wide so that the compare and subtract cannot overflow.
REQ-017 The block SHALL stay in CALC for exactly WIDTH cycles, counted by an internal step counter that is cleared on entry.
REQ-018 After the final step, the block SHALL enter DONE, load quotient and remainder, and drop busy to 0.
REQ-019 The block SHALL assert done for exactly the one cycle it spends in DONE, then return to IDLE.
REQ-020 For a nonzero divisor, latency SHALL be WIDTH+2 edges: done SHALL be high in the cycle following the (WIDTH+1)th rising edge after the start edge.
REQ-021 For a zero divisor, the block SHALL present quotient = all ones, remainder = the latched dividend and div_by_zero=1 with done, one cycle after the start edge.
REQ-022 div_by_zero SHALL hold its value until the next accepted start, which clears it.
REQ-023 quotient and remainder SHALL hold their last values until the next DONE and SHALL NOT change during CALC.
REQ-024 Any start asserted while busy=1 or while in DONE SHALL be ignored, with no effect on the operation in progress.
REQ-025 Changes on first or second after acceptance SHALL NOT affect the result.
REQ-026 Results SHALL satisfy quotient*second + remainder = first, with remainder < second, for every nonzero divisor.

Reset
REQ-027 Asserting reset_n=0 SHALL immediately force IDLE and clear quotient, remainder, busy, done, div_by_zero, the step counter and all internal registers to 0.
REQ-028 Reset asserted mid-CALC SHALL abort the operation with no done pulse; after release, the block SHALL accept a new start on the first edge.
REQ-029 The block SHALL leave reset synchronously to clk, with no spurious done on the first edge after release.

Verification
REQ-030 first=128, second=1, start pulse -> done exactly 10 cycles later (WIDTH=8); quotient=128, remainder=0, div_by_zero=0.
REQ-031 first=200, second=7 -> quotient=28, remainder=4; first=255, second=255 -> quotient=1, remainder=0; first=7, second=9 -> quotient=0, remainder=7.
REQ-032 first=5, second=0 -> done one cycle after the start edge, quotient=255, remainder=5, div_by_zero=1, busy never set across a CALC; next valid start clears div_by_zero.
REQ-033 start 200/7, then pulse start with 64/2 at step 3 -> the second request is ignored; the result stays 28/4, with exactly one done pulse.
REQ-034 start 200/7, assert reset_n=0 at step 4 -> all outputs 0 immediately, no done pulse; after release, 100/10 -> quotient=10, remainder=0.
REQ-035 A randomized sweep of 1000 operand pairs, including second=0, SHALL match the REQ-026 identity and the REQ-021 rule for every pair.
